// File: rtl/debug_hex_entry.sv
// Button-driven hex editor: debounced 5-way buttons edit an 8-digit word, centre commits it
// over a valid/ready handshake. Up/down auto-repeat while held in EDIT.
`timescale 1ns/1ps
module debug_hex_entry #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 2500000,
  parameter int REPEAT_RATE     = 500000
) (
  input  logic        clk_5M,
  input  logic        Rst,
  input  logic [4:0]  btn,
  output logic [31:0] value,
  output logic [2:0]  cursor,
  output logic        edit_active,
  output logic        commit_valid,
  output logic [31:0] commit_data,
  input  logic        commit_ready
);

  localparam int DW   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int HW   = (HMAX > 1) ? $clog2(HMAX + 1) : 1;
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] DELAY_LAST = HW'(REPEAT_DELAY - 1);
  localparam logic [HW-1:0] RATE_LAST  = HW'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {IDLE, EDIT, COMMIT} state_t;

  logic [4:0]          sync1_q, sync1_d, sync2_q, sync2_d;
  logic [4:0]          stable_q, stable_d;
  logic [4:0][DW-1:0]  deb_cnt_q, deb_cnt_d;
  logic [1:0][HW-1:0]  hold_cnt_q, hold_cnt_d;
  logic [1:0]          hold_rep_q, hold_rep_d;
  state_t              state_q, state_d;
  logic [31:0]         value_q, value_d;
  logic [2:0]          cursor_q, cursor_d;
  logic                edit_active_q, edit_active_d;
  logic                commit_valid_q, commit_valid_d;
  logic [31:0]         commit_data_q, commit_data_d;

  logic [4:0] press;
  logic [1:0] held;
  logic [1:0] rep;
  logic       evt_c, evt_u, evt_d, evt_l, evt_r;
  logic [4:0] dig_lsb;
  logic [3:0] cur_digit;

  // Debounce: a new level is accepted after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    sync1_d   = btn;
    sync2_d   = sync1_q;
    stable_d  = stable_q;
    deb_cnt_d = deb_cnt_q;
    press     = '0;
    for (int i = 0; i < 5; i++) begin
      if (sync2_q[i] == stable_q[i]) begin
        deb_cnt_d[i] = '0;
      end else if (deb_cnt_q[i] == DEB_LAST) begin
        stable_d[i]  = sync2_q[i];
        deb_cnt_d[i] = '0;
        press[i]     = sync2_q[i];
      end else begin
        deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
      end
    end
  end

  // Hold counters for up [0] and down [1]; hold_rep selects the delay or rate interval.
  always_comb begin
    held       = {stable_q[4], stable_q[1]};
    hold_cnt_d = hold_cnt_q;
    hold_rep_d = hold_rep_q;
    rep        = '0;
    for (int j = 0; j < 2; j++) begin
      if (!held[j]) begin
        hold_cnt_d[j] = '0;
        hold_rep_d[j] = 1'b0;
      end else if (hold_cnt_q[j] == (hold_rep_q[j] ? RATE_LAST : DELAY_LAST)) begin
        rep[j]        = 1'b1;
        hold_cnt_d[j] = '0;
        hold_rep_d[j] = 1'b1;
      end else begin
        hold_cnt_d[j] = hold_cnt_q[j] + 1'b1;
      end
    end
  end

  always_comb begin
    evt_c = press[0];
    evt_u = press[1] | (rep[0] & (state_q == EDIT));
    evt_d = press[4] | (rep[1] & (state_q == EDIT));
    evt_l = press[2];
    evt_r = press[3];
  end

  assign dig_lsb   = {cursor_q, 2'b00};
  assign cur_digit = value_q[dig_lsb +: 4];

  // The if/else chain below is the event priority: centre > up > down > left > right.
  always_comb begin
    state_d        = state_q;
    value_d        = value_q;
    cursor_d       = cursor_q;
    commit_valid_d = commit_valid_q;
    commit_data_d  = commit_data_q;
    case (state_q)
      IDLE: begin
        if (evt_c) begin
          state_d  = EDIT;
          cursor_d = 3'd0;
        end
      end
      EDIT: begin
        if (evt_c) begin
          commit_data_d  = value_q;
          commit_valid_d = 1'b1;
          state_d        = COMMIT;
        end else if (evt_u) begin
          value_d[dig_lsb +: 4] = cur_digit + 4'd1;
        end else if (evt_d) begin
          value_d[dig_lsb +: 4] = cur_digit - 4'd1;
        end else if (evt_l) begin
          cursor_d = cursor_q + 3'd1;
        end else if (evt_r) begin
          cursor_d = cursor_q - 3'd1;
        end
      end
      COMMIT: begin
        if (commit_ready && commit_valid_q) begin
          commit_valid_d = 1'b0;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    edit_active_d = (state_d == EDIT);
  end

  always_ff @(posedge clk_5M) begin
    if (Rst) begin
      sync1_q        <= '0;
      sync2_q        <= '0;
      stable_q       <= '0;
      deb_cnt_q      <= '0;
      hold_cnt_q     <= '0;
      hold_rep_q     <= '0;
      state_q        <= IDLE;
      value_q        <= '0;
      cursor_q       <= '0;
      edit_active_q  <= 1'b0;
      commit_valid_q <= 1'b0;
      commit_data_q  <= '0;
    end else begin
      sync1_q        <= sync1_d;
      sync2_q        <= sync2_d;
      stable_q       <= stable_d;
      deb_cnt_q      <= deb_cnt_d;
      hold_cnt_q     <= hold_cnt_d;
      hold_rep_q     <= hold_rep_d;
      state_q        <= state_d;
      value_q        <= value_d;
      cursor_q       <= cursor_d;
      edit_active_q  <= edit_active_d;
      commit_valid_q <= commit_valid_d;
      commit_data_q  <= commit_data_d;
    end
  end

  assign value        = value_q;
  assign cursor       = cursor_q;
  assign edit_active  = edit_active_q;
  assign commit_valid = commit_valid_q;
  assign commit_data  = commit_data_q;

endmodule

// File: tb/tb_debug_hex_entry.sv
// Bench for debug_hex_entry: directed scenarios plus random button/ready/reset traffic,
// all compared every cycle against a behavioural model of the editor.
`timescale 1ns/1ps
module tb_debug_hex_entry;

  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RR = 5;

  logic        clk_5M = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  btn = '0;
  logic        commit_ready = 1'b0;
  logic [31:0] value, commit_data;
  logic [2:0]  cursor;
  logic        edit_active, commit_valid;

  int checks = 0;
  int failures = 0;
  int cv_hi = 0;
  logic [31:0] last_cd = '0;

  debug_hex_entry #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut (
    .clk_5M(clk_5M), .Rst(rst), .btn(btn), .value(value), .cursor(cursor),
    .edit_active(edit_active), .commit_valid(commit_valid),
    .commit_data(commit_data), .commit_ready(commit_ready)
  );

  always #100 clk_5M = ~clk_5M;

  // Reference model: sync pipeline, run-length debounce, hold time since press.
  logic [4:0]  m_s1 = '0, m_s2 = '0, m_stable = '0;
  int          m_run[5];
  int          m_held[5];
  int          m_state = 0;  // 0 idle, 1 edit, 2 commit
  logic [31:0] m_value = '0, m_cd = '0;
  int          m_cursor = 0;
  logic        m_cv = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit rep_due(input int h);
    return (h == RD) || (h > RD && ((h - RD) % RR) == 0);
  endfunction

  task automatic model_edge();
    logic [4:0] prs;
    bit ru, rdn, c, u, dn, l, r;
    int k;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_stable = '0;
      for (int i = 0; i < 5; i++) begin m_run[i] = 0; m_held[i] = 0; end
      m_state = 0; m_value = '0; m_cd = '0; m_cursor = 0; m_cv = 1'b0;
      return;
    end
    ru = 0; rdn = 0;
    if (m_stable[1]) begin m_held[1]++; ru = rep_due(m_held[1]); end else m_held[1] = 0;
    if (m_stable[4]) begin m_held[4]++; rdn = rep_due(m_held[4]); end else m_held[4] = 0;
    if (m_state != 1) begin ru = 0; rdn = 0; end
    prs = '0;
    for (int i = 0; i < 5; i++) begin
      if (m_s2[i] !== m_stable[i]) begin
        m_run[i]++;
        if (m_run[i] == D) begin
          m_stable[i] = m_s2[i];
          m_run[i] = 0;
          prs[i] = m_s2[i];
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = btn;
    c = prs[0]; u = prs[1] | ru; dn = prs[4] | rdn; l = prs[2]; r = prs[3];
    k = m_cursor * 4;
    case (m_state)
      0: if (c) begin m_state = 1; m_cursor = 0; end
      1: begin
        if (c) begin m_cd = m_value; m_cv = 1'b1; m_state = 2; end
        else if (u) m_value[k +: 4] = (m_value[k +: 4] + 1) % 16;
        else if (dn) m_value[k +: 4] = (m_value[k +: 4] + 15) % 16;
        else if (l) m_cursor = (m_cursor + 1) % 8;
        else if (r) m_cursor = (m_cursor + 7) % 8;
      end
      default: if (commit_ready) begin m_cv = 1'b0; m_state = 0; end
    endcase
  endtask

  task automatic tick();
    @(posedge clk_5M);
    model_edge();
    #1;
    check("value", value, m_value);
    check("cursor", {29'd0, cursor}, m_cursor[31:0]);
    check("edit_active", {31'd0, edit_active}, {31'd0, m_state == 1});
    check("commit_valid", {31'd0, commit_valid}, {31'd0, m_cv});
    check("commit_data", commit_data, m_cd);
    if (commit_valid) begin cv_hi++; last_cd = commit_data; end
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic tap(input int b);
    btn[b] = 1'b1;
    run(D + 4);
    btn[b] = 1'b0;
    run(D + 4);
  endtask

  initial begin
    for (int i = 0; i < 5; i++) begin m_run[i] = 0; m_held[i] = 0; end
    run(3);
    check("rst_value", value, 32'h0);
    check("rst_cursor", {29'd0, cursor}, 32'h0);
    check("rst_edit", {31'd0, edit_active}, 32'h0);
    check("rst_cv", {31'd0, commit_valid}, 32'h0);
    check("rst_cd", commit_data, 32'h0);
    rst = 1'b0;

    // Edit sequence with ready already high
    commit_ready = 1'b1;
    tap(0);
    repeat (3) tap(1);
    tap(2);
    tap(4);
    cv_hi = 0;
    tap(0);
    run(4);
    check("edit_commit_data", last_cd, 32'h0000_00F3);
    check("edit_cv_len", cv_hi, 32'd1);
    check("edit_value_idle", value, 32'h0000_00F3);
    check("edit_idle", {31'd0, edit_active}, 32'h0);

    // Cursor and digit wrap
    rst = 1'b1; run(1); rst = 1'b0;
    tap(0);
    tap(1); tap(1);
    tap(3);
    check("wrap_cursor", {29'd0, cursor}, 32'd7);
    tap(4);
    check("wrap_down", value, 32'hF000_0002);
    tap(1);
    check("wrap_up_hi", {28'd0, value[31:28]}, 32'h0);
    check("wrap_up_lo", {4'd0, value[27:0]}, 32'h0000_0002);

    // Bounce on up: no event while bouncing, one after settling, none on release
    btn[1] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      run(2);
      btn[1] = ~btn[1];
    end
    check("bounce_none", value, 32'h0000_0002);
    btn[1] = 1'b1;
    run(10);
    check("bounce_one", value, 32'h1000_0002);
    btn[1] = 1'b0;
    run(10);
    check("bounce_release", value, 32'h1000_0002);

    // Auto-repeat; left press lands on the +20 repeat and must be dropped
    btn[1] = 1'b1;
    run(20);
    btn[2] = 1'b1;
    run(12);
    btn[2] = 1'b0;
    run(12);
    btn[1] = 1'b0;
    run(12);
    check("repeat_value", value, 32'h7000_0002);
    check("repeat_cursor", {29'd0, cursor}, 32'd7);

    // Backpressure on commit while pressing up
    commit_ready = 1'b0;
    tap(0);
    tap(1); tap(1);
    check("bp_cv", {31'd0, commit_valid}, 32'h1);
    check("bp_cd", commit_data, 32'h7000_0002);
    check("bp_value", value, 32'h7000_0002);
    commit_ready = 1'b1;
    run(1);
    commit_ready = 1'b0;
    check("bp_done_cv", {31'd0, commit_valid}, 32'h0);
    check("bp_done_idle", {31'd0, edit_active}, 32'h0);
    run(2);

    // Reset during pending commit, centre held through reset
    tap(0);
    tap(0);
    check("mid_cv", {31'd0, commit_valid}, 32'h1);
    btn[0] = 1'b1;
    rst = 1'b1;
    run(1);
    check("mrst_value", value, 32'h0);
    check("mrst_cv", {31'd0, commit_valid}, 32'h0);
    check("mrst_cd", commit_data, 32'h0);
    check("mrst_edit", {31'd0, edit_active}, 32'h0);
    run(1);
    rst = 1'b0;
    run(10);
    check("held_through_rst", {31'd0, edit_active}, 32'h1);
    btn[0] = 1'b0;
    run(10);

    // Random traffic
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 9) == 0) btn[$urandom_range(0, 4)] ^= 1'b1;
      commit_ready = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 799) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
